// File: rtl/spi_pkg.sv
// Shared SPI definitions: transaction FSM state encodings and counter-width helpers.
package spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  function automatic int spi_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Counters never collapse to zero bits, even for degenerate parameter values.
  function automatic int spi_cnt_w(input int value);
    return (spi_clog2(value) < 1) ? 1 : spi_clog2(value);
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the search starts at the rotating pointer.
module spi_rr_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = spi_cnt_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id,
  output logic               grant_any
);

  logic [IDW-1:0] ptr;

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant_id   = IDW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  // The client just served becomes lowest priority for the next round.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one spi_master among NUM_REQ clients: round-robin accept, one transfer at a time,
// timeout watchdog on spi_done, and an enforced idle gap between transfers.
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_err,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         data_send,
  output logic                          spi_start,
  input  logic                          spi_done,
  input  logic [DATA_WIDTH-1:0]         data_recv
);

  localparam int IDW = spi_cnt_w(NUM_REQ);
  localparam int TW  = spi_cnt_w(TIMEOUT_CYCLES);
  localparam int GW  = spi_cnt_w(GAP_CYCLES + 1);

  logic [2:0]         state;
  logic [IDW-1:0]     id;
  logic [TW-1:0]      to_cnt;
  logic [GW-1:0]      gap_cnt;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic               grant_any;
  logic               accept;

  assign accept     = (state == ST_IDLE) && grant_any;
  assign req_ready  = (state == ST_IDLE) ? grant : '0;
  assign spi_start  = (state == ST_START);
  assign busy       = (state != ST_IDLE);
  assign resp_valid = (state == ST_RESP) ? (NUM_REQ'(1) << id) : '0;

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      id        <= '0;
      data_send <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            id        <= grant_id;
            data_send <= req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
            state     <= ST_START;
          end
        end
        ST_START: begin
          to_cnt <= '0;
          state  <= ST_WAIT;
        end
        // spi_done is checked first so a completion on the last allowed cycle still wins.
        ST_WAIT: begin
          if (spi_done) begin
            resp_data <= data_recv;
            resp_err  <= 1'b0;
            state     <= ST_RESP;
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
            state     <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          gap_cnt <= '0;
          state   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
        ST_GAP: begin
          if (int'(gap_cnt) >= GAP_CYCLES - 1) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: behavioural master/slave model, round-robin reference, scoreboard.
module tb_spi_txn_arbiter;

  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int GAP = 4;
  localparam int TO  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    resp_valid;
  logic [DW-1:0]    resp_data;
  logic             resp_err;
  logic             busy;
  logic [DW-1:0]    data_send;
  logic             spi_start;
  logic             spi_done = 1'b0;
  logic [DW-1:0]    data_recv = '0;

  spi_txn_arbiter #(
    .DATA_WIDTH     (DW),
    .NUM_REQ        (NR),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy),
    .data_send  (data_send),
    .spi_start  (spi_start),
    .spi_done   (spi_done),
    .data_recv  (data_recv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            client;
    logic [DW-1:0] data;
    logic          err;
    int            at;
  } exp_t;

  // Monitor-owned state
  int            checks = 0;
  int            errors = 0;
  exp_t          sb[$];
  int            mptr = 0;
  int            acc_cyc = -100;
  int            acc_client = 0;
  logic [DW-1:0] acc_data = '0;
  logic [NR-1:0] acc_mask = '0;
  int            done_cyc = -1;
  logic [DW-1:0] done_data = '0;
  bit            inflight = 1'b0;
  int            idle_from = 0;
  int            n_acc = 0;
  int            n_start = 0;
  bit            rst_prev = 1'b0;

  // Stimulus-owned state
  bit            force_en = 1'b1;
  int            force_L = 3;
  logic [DW-1:0] force_data = 8'h5A;
  bit            wd_fail = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Slave/master model: pulses spi_done with the chosen word at the scheduled cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cyc == done_cyc) begin
        spi_done  = 1'b1;
        data_recv = done_data;
      end else begin
        spi_done  = 1'b0;
        data_recv = DW'($urandom);
      end
    end
  end

  always @(negedge clk) begin : mon
    int            g;
    int            idx;
    int            L;
    int            r;
    bit            model_idle;
    logic [NR-1:0] exp_ready;
    logic [NR-1:0] acc;
    logic [DW-1:0] d;
    exp_t          e;
    if (rst) begin
      sb.delete();
      mptr      = 0;
      inflight  = 1'b0;
      idle_from = cyc + 1;
      done_cyc  = -1;
      acc_cyc   = -100;
      acc_mask  = '0;
      rst_prev  = 1'b1;
    end else begin
      if (rst_prev) begin
        chk("rst_resp_valid", 32'(resp_valid), 32'(0));
        chk("rst_resp_data", 32'(resp_data), 32'(0));
        chk("rst_resp_err", 32'(resp_err), 32'(0));
        chk("rst_data_send", 32'(data_send), 32'(0));
        chk("rst_spi_start", 32'(spi_start), 32'(0));
        rst_prev = 1'b0;
      end
      chk("watchdog", 32'(wd_fail), 32'(0));

      model_idle = !inflight && (cyc >= idle_from);
      g = -1;
      for (int k = 0; k < NR; k++) begin
        idx = (mptr + k) % NR;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      exp_ready = (model_idle && g >= 0) ? (NR'(1) << g) : '0;
      chk("busy", 32'(busy), 32'(!model_idle));
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("spi_start", 32'(spi_start), 32'(cyc == acc_cyc + 1));

      acc      = req_valid & req_ready;
      acc_mask = acc;
      if (acc != '0) begin
        acc_client = (g >= 0) ? g : 0;
        acc_data   = req_data[acc_client*DW +: DW];
        acc_cyc    = cyc;
        mptr       = (acc_client + 1) % NR;
        inflight   = 1'b1;
        n_acc++;
      end

      if (spi_start) begin
        n_start++;
        chk("data_send", 32'(data_send), 32'(acc_data));
        if (force_en) begin
          L = force_L;
          d = force_data;
        end else begin
          r = int'($urandom_range(0, 7));
          if (r == 0) L = 0;
          else if (r == 1) L = TO + 1;
          else L = int'($urandom_range(1, TO));
          d = DW'($urandom);
        end
        done_cyc  = (L > 0) ? cyc + L : -1;
        done_data = d;
        e.client  = acc_client;
        if (L >= 1 && L <= TO) begin
          e.err  = 1'b0;
          e.data = d;
          e.at   = cyc + L + 1;
        end else begin
          e.err  = 1'b1;
          e.data = '0;
          e.at   = cyc + TO + 1;
        end
        sb.push_back(e);
      end

      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("resp_onehot", 32'(resp_valid), 32'(NR'(1) << e.client));
          chk("resp_data", 32'(resp_data), 32'(e.data));
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("resp_cycle", 32'(cyc), 32'(e.at));
          inflight  = 1'b0;
          idle_from = cyc + GAP + 1;
        end
      end else if (sb.size() != 0 && cyc > sb[0].at) begin
        e = sb.pop_front();
        chk("resp_missing", 32'(cyc), 32'(e.at));
        inflight  = 1'b0;
        idle_from = cyc + GAP + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc_mask;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(req_valid == '0 && !busy && sb.size() == 0) && n < budget);
    if (n >= budget) wd_fail = 1'b1;
  endtask

  task automatic post(input int client, input logic [DW-1:0] data);
    req_data[client*DW +: DW] = data;
    req_valid[client]         = 1'b1;
  endtask

  initial begin : stim
    int target;
    int n;
    int s0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Two simultaneous requests right after reset: 0 then 3
    force_en = 1'b1; force_L = 3; force_data = 8'h5A;
    post(0, 8'h11);
    post(3, 8'h33);
    wait_done(200);

    // Single request, client 2
    force_L = 5; force_data = 8'h3C;
    post(2, 8'hA5);
    wait_done(200);

    // Timeout, late done ignored, done on the last allowed cycle, then normal service
    force_L = 0;
    post(1, 8'h21);
    wait_done(200);
    force_L = TO + 1; force_data = 8'hEE;
    post(3, 8'h43);
    wait_done(200);
    force_L = TO; force_data = 8'h96;
    post(0, 8'h10);
    wait_done(200);
    force_L = 2; force_data = 8'h7E;
    post(1, 8'h22);
    wait_done(200);

    // All clients held valid for 8 grants
    force_en = 1'b0;
    target = n_acc + 8;
    n = 0;
    while (n_acc < target && n < 2000) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i]) post(i, DW'($urandom));
      step();
      n++;
    end
    if (n >= 2000) wd_fail = 1'b1;
    wait_done(500);

    // Random traffic
    target = n_acc + 40;
    n = 0;
    while (n_acc < target && n < 4000) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0) post(i, DW'($urandom));
      step();
      n++;
    end
    if (n >= 4000) wd_fail = 1'b1;
    wait_done(500);

    // Reset in the middle of WAIT: transfer aborted, pointer back to 0
    force_en = 1'b1; force_L = 0; force_data = '0;
    post(2, 8'h77);
    s0 = n_start;
    n = 0;
    while (n_start == s0 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) wd_fail = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    force_L = 3; force_data = 8'hC3;
    post(1, 8'h12);
    post(3, 8'h34);
    wait_done(200);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : guard
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 1ms");
    $fatal(1);
  end

endmodule
